// File: rtl/axi_sram_pkg.sv
// Shared constants for the AXI3 single-beat SRAM slave.
// Response codes and one-hot FSM state encodings.
package axi_sram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [4:0] S_IDLE   = 5'b00001;
    localparam logic [4:0] S_RD_MEM = 5'b00010;
    localparam logic [4:0] S_R_RESP = 5'b00100;
    localparam logic [4:0] S_W_MEM  = 5'b01000;
    localparam logic [4:0] S_B_RESP = 5'b10000;

endpackage

// File: rtl/axi_sram_ram.sv
// Single-port synchronous word RAM with byte write enables.
// Registered read; contents are never reset.
module axi_sram_ram #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 single-beat slave in front of an internal word RAM.
// Serves one read or one write at a time; write completes before next AR.
module axi_sram_slave
    import axi_sram_pkg::*;
#(
    parameter int          ID_W      = 4,
    parameter int          MEM_AW    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h1C00_0000
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic [ID_W-1:0] arid,
    input  logic [31:0]     araddr,
    input  logic [7:0]      arlen,
    input  logic [2:0]      arsize,
    input  logic            arvalid,
    output logic            arready,
    output logic [ID_W-1:0] rid,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic            rvalid,
    input  logic            rready,
    input  logic [ID_W-1:0] awid,
    input  logic [31:0]     awaddr,
    input  logic [7:0]      awlen,
    input  logic            awvalid,
    output logic            awready,
    input  logic [ID_W-1:0] wid,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,
    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready
);

    logic [4:0]        state;
    logic              aw_got;
    logic              w_got;
    logic              rd_pend;
    logic [MEM_AW-1:0] ar_idx;
    logic [MEM_AW-1:0] aw_idx;
    logic [1:0]        ar_resp;
    logic [1:0]        aw_resp;
    logic [31:0]       w_data;
    logic [3:0]        w_strb;
    logic              is_idle;
    logic              ar_hs;
    logic              aw_hs;
    logic              w_hs;
    logic              ram_en;
    logic              wr_en;
    logic [3:0]        ram_we;
    logic [MEM_AW-1:0] ram_addr;
    logic [31:0]       ram_rdata;
    logic              unused;

    function automatic logic [1:0] addr_chk(input logic [31:0] a,
                                            input logic [7:0]  len);
        if (a[31:MEM_AW+2] != BASE_ADDR[31:MEM_AW+2]) return RESP_DECERR;
        if (len != 8'd0) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    assign is_idle = (state == S_IDLE);
    assign arready = aresetn & is_idle & !aw_got & !w_got;
    assign awready = aresetn & is_idle & !aw_got & !(arvalid & !w_got);
    assign wready  = aresetn & is_idle & !w_got & !(arvalid & !aw_got);
    assign ar_hs   = arvalid & arready;
    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;
    assign rlast   = 1'b1;

    // Read issues in the first RD_MEM cycle; data is captured in the second.
    assign wr_en    = (state == S_W_MEM) && (aw_resp == RESP_OKAY) && (w_strb != 4'd0);
    assign ram_en   = ((state == S_RD_MEM) && !rd_pend) || wr_en;
    assign ram_we   = wr_en ? w_strb : 4'd0;
    assign ram_addr = (state == S_W_MEM) ? aw_idx : ar_idx;

    assign unused = ^{arsize, wid, wlast, araddr[1:0], awaddr[1:0]};

    axi_sram_ram #(.AW(MEM_AW)) u_ram (
        .clk   (aclk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (w_data),
        .rdata (ram_rdata)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= S_IDLE;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            rd_pend <= 1'b0;
            ar_idx  <= '0;
            aw_idx  <= '0;
            ar_resp <= RESP_OKAY;
            aw_resp <= RESP_OKAY;
            w_data  <= '0;
            w_strb  <= '0;
            rid     <= '0;
            bid     <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            rvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            bvalid  <= 1'b0;
        end else begin
            unique case (1'b1)
                (state == S_IDLE): begin
                    if (ar_hs) begin
                        rid     <= arid;
                        ar_idx  <= araddr[MEM_AW+1:2];
                        ar_resp <= addr_chk(araddr, arlen);
                        rd_pend <= 1'b0;
                        state   <= S_RD_MEM;
                    end else begin
                        if (aw_hs) begin
                            aw_got  <= 1'b1;
                            bid     <= awid;
                            aw_idx  <= awaddr[MEM_AW+1:2];
                            aw_resp <= addr_chk(awaddr, awlen);
                        end
                        if (w_hs) begin
                            w_got  <= 1'b1;
                            w_data <= wdata;
                            w_strb <= wstrb;
                        end
                        if (aw_got && w_got) state <= S_W_MEM;
                    end
                end
                (state == S_RD_MEM): begin
                    if (rd_pend) begin
                        rdata   <= (ar_resp == RESP_OKAY) ? ram_rdata : 32'd0;
                        rresp   <= ar_resp;
                        rvalid  <= 1'b1;
                        rd_pend <= 1'b0;
                        state   <= S_R_RESP;
                    end else begin
                        rd_pend <= 1'b1;
                    end
                end
                (state == S_R_RESP): begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                (state == S_W_MEM): begin
                    bresp  <= aw_resp;
                    bvalid <= 1'b1;
                    state  <= S_B_RESP;
                end
                (state == S_B_RESP): begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        aw_got <= 1'b0;
                        w_got  <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: directed AXI traffic,
// expected R/B responses queued and checked by a monitor.
module tb_axi_sram_slave;

    logic        aclk = 0;
    logic        aresetn = 0;
    logic [3:0]  arid = 0;
    logic [31:0] araddr = 0;
    logic [7:0]  arlen = 0;
    logic [2:0]  arsize = 0;
    logic        arvalid = 0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1;
    logic [3:0]  awid = 0;
    logic [31:0] awaddr = 0;
    logic [7:0]  awlen = 0;
    logic        awvalid = 0;
    logic        awready;
    logic [3:0]  wid = 0;
    logic [31:0] wdata = 0;
    logic [3:0]  wstrb = 0;
    logic        wlast = 0;
    logic        wvalid = 0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1;

    axi_sram_slave dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rexp_t rq[$];
    bexp_t bq[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ar_cyc = 0;
    int wr_cyc = 0;
    int aw_hs_cyc = 0;
    int w_hs_cyc = 0;
    int r_done = 0;
    int b_done = 0;
    logic rv_prev = 0;
    logic bv_prev = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s got=timeout exp=handshake t=%0t", name, $time);
    endtask

    // Monitor: pops the scoreboard on every R/B handshake.
    always @(negedge aclk) begin
        rexp_t re;
        bexp_t be;
        if (aresetn) begin
            if (rvalid && !rv_prev) chk("r_latency", cyc - ar_cyc, 2);
            if (bvalid && !bv_prev) chk("b_latency", cyc - wr_cyc, 2);
            if (rvalid && rready) begin
                if (rq.size() == 0) begin
                    fail_now("r_unexpected");
                end else begin
                    re = rq.pop_front();
                    chk("rid", {28'd0, rid}, {28'd0, re.id});
                    chk("rdata", rdata, re.data);
                    chk("rresp", {30'd0, rresp}, {30'd0, re.resp});
                    chk("rlast", {31'd0, rlast}, 1);
                end
                r_done++;
            end
            if (bvalid && bready) begin
                if (bq.size() == 0) begin
                    fail_now("b_unexpected");
                end else begin
                    be = bq.pop_front();
                    chk("bid", {28'd0, bid}, {28'd0, be.id});
                    chk("bresp", {30'd0, bresp}, {30'd0, be.resp});
                end
                b_done++;
            end
        end
        rv_prev = rvalid;
        bv_prev = bvalid;
    end

    task automatic ar_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len);
        int n = 0;
        arid = id; araddr = a; arlen = len; arsize = 3'd2; arvalid = 1;
        @(negedge aclk);
        while (!arready && n < 100) begin n++; @(negedge aclk); end
        if (!arready) begin
            fail_now("ar_timeout");
        end else begin
            @(posedge aclk); #1;
            ar_cyc = cyc;
        end
        arvalid = 0;
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len);
        int n = 0;
        awid = id; awaddr = a; awlen = len; awvalid = 1;
        @(negedge aclk);
        while (!awready && n < 100) begin n++; @(negedge aclk); end
        if (!awready) begin
            fail_now("aw_timeout");
        end else begin
            @(posedge aclk); #1;
            aw_hs_cyc = cyc;
            if (cyc > wr_cyc) wr_cyc = cyc;
        end
        awvalid = 0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        wdata = d; wstrb = s; wlast = 1; wvalid = 1;
        @(negedge aclk);
        while (!wready && n < 100) begin n++; @(negedge aclk); end
        if (!wready) begin
            fail_now("w_timeout");
        end else begin
            @(posedge aclk); #1;
            w_hs_cyc = cyc;
            if (cyc > wr_cyc) wr_cyc = cyc;
        end
        wvalid = 0;
    endtask

    task automatic wait_r(input int target);
        int n = 0;
        while (r_done < target && n < 200) begin @(negedge aclk); n++; end
        if (r_done < target) fail_now("r_wait");
    endtask

    task automatic wait_b(input int target);
        int n = 0;
        while (b_done < target && n < 200) begin @(negedge aclk); n++; end
        if (b_done < target) fail_now("b_wait");
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [7:0] len, input logic [1:0] er);
        int t = b_done + 1;
        bq.push_back('{id: id, resp: er});
        @(posedge aclk); #1;
        fork
            aw_send(id, a, len);
            w_send(d, s);
        join
        wait_b(t);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [31:0] ed, input logic [1:0] er);
        int t = r_done + 1;
        rq.push_back('{id: id, data: ed, resp: er});
        @(posedge aclk); #1;
        ar_send(id, a, len);
        wait_r(t);
    endtask

    initial begin
        int b0;
        int n;
        // Reset state
        #1;
        chk("rst_rvalid", {31'd0, rvalid}, 0);
        chk("rst_bvalid", {31'd0, bvalid}, 0);
        chk("rst_arready", {31'd0, arready}, 0);
        repeat (3) @(posedge aclk);
        @(negedge aclk); aresetn = 1;
        #1;
        chk("rel_arready", {31'd0, arready}, 1);
        chk("rel_awready", {31'd0, awready}, 1);
        chk("rel_wready", {31'd0, wready}, 1);
        chk("rst_rid", {28'd0, rid}, 0);
        chk("rst_rdata", rdata, 0);

        // Write then read back
        do_write(4'd3, 32'h1C00_0010, 32'hDEAD_BEEF, 4'hF, 8'd0, 2'b00);
        do_read(4'd5, 32'h1C00_0010, 8'd0, 32'hDEAD_BEEF, 2'b00);

        // Partial strobe merge
        do_write(4'd1, 32'h1C00_0020, 32'h1122_3344, 4'hF, 8'd0, 2'b00);
        do_write(4'd2, 32'h1C00_0022, 32'hAABB_CCDD, 4'b0101, 8'd0, 2'b00);
        do_read(4'd6, 32'h1C00_0020, 8'd0, 32'h11BB_33DD, 2'b00);

        // W ahead of AW by 3 cycles
        b0 = b_done;
        bq.push_back('{id: 4'd7, resp: 2'b00});
        @(posedge aclk); #1;
        fork
            w_send(32'hCAFE_F00D, 4'hF);
            begin
                repeat (3) @(posedge aclk);
                #1;
                aw_send(4'd7, 32'h1C00_0030, 8'd0);
            end
        join
        wait_b(b0 + 1);
        repeat (5) @(negedge aclk);
        chk("w_before_aw", {31'd0, (aw_hs_cyc > w_hs_cyc)}, 1);
        chk("one_bvalid", b_done - b0, 1);
        do_read(4'd8, 32'h1C00_0030, 8'd0, 32'hCAFE_F00D, 2'b00);

        // Read wins contention with a simultaneous write
        b0 = b_done;
        n = r_done;
        rq.push_back('{id: 4'd4, data: 32'hDEAD_BEEF, resp: 2'b00});
        bq.push_back('{id: 4'd9, resp: 2'b00});
        @(posedge aclk); #1;
        fork
            ar_send(4'd4, 32'h1C00_0010, 8'd0);
            aw_send(4'd9, 32'h1C00_0040, 8'd0);
            w_send(32'h0102_0304, 4'hF);
            begin
                @(negedge aclk);
                chk("cont_arready", {31'd0, arready}, 1);
                chk("cont_awready", {31'd0, awready}, 0);
                chk("cont_wready", {31'd0, wready}, 0);
            end
        join
        chk("cont_read_first", {31'd0, (aw_hs_cyc > ar_cyc)}, 1);
        wait_r(n + 1);
        wait_b(b0 + 1);
        do_read(4'd10, 32'h1C00_0040, 8'd0, 32'h0102_0304, 2'b00);

        // Backpressure on R
        n = r_done;
        rq.push_back('{id: 4'd9, data: 32'h11BB_33DD, resp: 2'b00});
        rready = 0;
        @(posedge aclk); #1;
        ar_send(4'd9, 32'h1C00_0020, 8'd0);
        repeat (3) @(negedge aclk);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("bp_rvalid", {31'd0, rvalid}, 1);
            chk("bp_rdata", rdata, 32'h11BB_33DD);
            chk("bp_rid", {28'd0, rid}, 9);
        end
        @(posedge aclk); #1;
        rready = 1;
        wait_r(n + 1);

        // Error responses
        do_read(4'd11, 32'h0000_0000, 8'd0, 32'h0, 2'b11);
        do_read(4'd12, 32'h1C00_0010, 8'd1, 32'h0, 2'b10);
        do_write(4'd13, 32'h1C00_0010, 32'h5555_5555, 4'hF, 8'd3, 2'b10);
        do_write(4'd14, 32'h2000_0010, 32'h6666_6666, 4'hF, 8'd0, 2'b11);
        do_read(4'd15, 32'h1C00_0010, 8'd0, 32'hDEAD_BEEF, 2'b00);

        // Reset while in R_RESP
        rready = 0;
        @(posedge aclk); #1;
        ar_send(4'd2, 32'h1C00_0030, 8'd0);
        n = 0;
        while (!rvalid && n < 20) begin @(negedge aclk); n++; end
        chk("pre_rst_rvalid", {31'd0, rvalid}, 1);
        #2 aresetn = 0;
        #1;
        chk("mid_rst_rvalid", {31'd0, rvalid}, 0);
        chk("mid_rst_arready", {31'd0, arready}, 0);
        @(negedge aclk);
        aresetn = 1;
        rready = 1;
        @(posedge aclk); #1;
        chk("post_rst_arready", {31'd0, arready}, 1);
        do_read(4'd3, 32'h1C00_0030, 8'd0, 32'hCAFE_F00D, 2'b00);

        repeat (5) @(negedge aclk);
        chk("rq_drained", rq.size(), 0);
        chk("bq_drained", bq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
AXI3 single-beat slave that terminates the CPU's AXI bus onto an internal synchronous word RAM; it is the responder matching the CPU-side SRAM-to-AXI converter. It is used as the memory model in CPU simulation and as on-chip RAM. It serves one transaction at a time, either a read or a write, with byte-strobed writes and address-range error responses.

Parameters:
ID_W, 4, width of arid/rid/awid/wid/bid
MEM_AW, 12, log2 of RAM depth in 32-bit words (default 16 KiB)
BASE_ADDR, 32'h1C00_0000, window base; bits [31:MEM_AW+2] select the window

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
arid  in  ID_W  read id
araddr  in  32  read byte address
arlen  in  8  burst length; must be 0
arsize  in  3  access size; does not affect the access, full word always returned
arvalid  in  1  read address valid
arready  out  1  read address ready
rid  out  ID_W  echo of the latched arid
rdata  out  32  read data
rresp  out  2  response: 00 OKAY, 10 SLVERR, 11 DECERR
rlast  out  1  constant 1
rvalid  out  1  read data valid
rready  in  1  read data ready
awid  in  ID_W  write id
awaddr  in  32  write byte address
awlen  in  8  burst length; must be 0
awvalid  in  1  write address valid
awready  out  1  write address ready
wid  in  ID_W  write-data id; ignored
wdata  in  32  write data
wstrb  in  4  byte enables
wlast  in  1  last beat; ignored, since every beat is treated as last
wvalid  in  1  write data valid
wready  out  1  write data ready
bid  out  ID_W  echo of the latched awid
bresp  out  2  write response, same codes as rresp
bvalid  out  1  write response valid
bready  in  1  write response ready

Behaviour:
- Reset: aresetn low asynchronously clears everything. State goes to IDLE, aw_got/w_got go to 0, and rvalid/bvalid/arready/awready/wready all go to 0. rid, bid, rdata and rresp go to 0. RAM contents are not reset. A reset mid-transaction drops that transaction with no response.
- States: IDLE, RD_MEM, R_RESP, W_MEM, B_RESP. The encoding is one-hot.
- Ready generation:
  - arready = aresetn & IDLE & !aw_got & !w_got. A partially captured write blocks new reads.
  - awready = aresetn & IDLE & !aw_got & !(arvalid & !w_got).
  - wready = aresetn & IDLE & !w_got & !(arvalid & !aw_got).
  - So when IDLE with nothing latched and arvalid is high together with awvalid/wvalid, the read wins.
- Read path, AR handshake at edge T:
  - Latch arid and araddr, compute in_range and err, and go to RD_MEM.
  - In RD_MEM the RAM is read at word index araddr[MEM_AW+1:2].
  - At edge T+2 the state goes to R_RESP with rvalid=1 and the data registered. Read latency is 2 cycles from the AR handshake.
  - rvalid, rdata, rresp and rid stay stable until rready. On rvalid&rready go to IDLE; the next AR can be accepted in the following cycle.
- Write path:
  - AW handshake sets aw_got and latches awid, awaddr and awlen.
  - W handshake sets w_got and latches wdata and wstrb.
  - AW and W may arrive in either order or in the same cycle.
  - In the cycle both flags are set (IDLE) go to W_MEM. In W_MEM the RAM is written with byte enables = wstrb, unless there is an error or wstrb=0.
  - Next go to B_RESP with bvalid=1, stable until bready. On handshake clear aw_got/w_got and go to IDLE.
  - bvalid rises 2 cycles after the later of the AW/W handshakes.
- Errors, checked in this order:
  - addr[31:MEM_AW+2] != BASE_ADDR[31:MEM_AW+2] gives DECERR (11).
  - Otherwise len != 0 gives SLVERR (10). Only one beat is served, with rlast=1.
  - An errored transaction performs no RAM write, and an errored read returns rdata=0.
- Address bits [1:0] are ignored; the word is always aligned.
- A read to an address written by the immediately preceding write returns the new data, because the write completes in W_MEM before any AR can be accepted.

Decomposition:
- Package axi_sram_pkg holds:
  - resp codes RESP_OKAY/SLVERR/DECERR;
  - state localparams S_IDLE, S_RD_MEM, S_R_RESP, S_W_MEM, S_B_RESP.
- Sub-module axi_sram_ram: single-port synchronous RAM, 2^MEM_AW x 32, with a 4-bit byte write enable and 1-cycle registered read. It has no reset.

Test Plan:
- Write/read back: AW 0x1C000010 with W 0xDEADBEEF/strb F, then AR at the same address -> bvalid 2 cycles after the handshake with bresp 00, then rdata 0xDEADBEEF, rresp 00, rvalid 2 cycles after AR.
- Partial strobe: write 0x11223344 strb F, then 0xAABBCCDD strb 0101 -> read gives 0x11BB33DD.
- W before AW: wvalid 3 cycles ahead of awvalid -> wready taken first, awready taken later, exactly one bvalid, memory updated.
- Contention: arvalid and awvalid+wvalid raised in the same IDLE cycle -> AR accepted first, R completes, then AW/W accepted and B returned.
- Backpressure/errors: hold rready=0 for 5 cycles -> rvalid/rdata/rid stable. AR to 0x00000000 -> rresp 11, rdata 0. AW with awlen=3 -> bresp 10 and memory unchanged.
- Reset mid-op: deassert aresetn while in R_RESP -> rvalid drops immediately. After release, arready=1 on the first clock and earlier-written RAM data is still readable.
